xy_wormhole_router: RTL and testbench

Parametrised packet-switching successor to the single-decision combinational route comparator. It accepts flit streams on `NUM_IN` input channels and computes an XY dimension-order route from each head flit against the node's own coordinates. Each of five output ports is locked to one packet for its whole duration (wormhole), and contention is resolved by per-output round-robin. It sits between the node's input buffers and the link drivers of a 2-D mesh tile.

---
 rtl/xy_wormhole_router.sv | 224 ++++++++++++++++++++++
 tb/tb_xy_wormhole_router.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xy_wormhole_router.sv
// XY dimension-order wormhole switch: NUM_IN inputs onto 5 ports (L,E,W,N,S); XY_ROUTER_ERR_CNT_EN builds the stray-flit counter.
// Latency: a flit accepted in cycle N is on out_* in cycle N+1; one flit/cycle/port, all five ports concurrent.
// Backpressure: in_ready follows the target output register being free (!out_valid | out_ready); a stalled port blocks only its owner.
module xy_wormhole_router #(
    parameter int NUM_IN  = 4,
    parameter int COORD_W = 4,
    parameter int DATA_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [COORD_W-1:0]       my_x,
    input  logic [COORD_W-1:0]       my_y,
    input  logic [NUM_IN-1:0]        in_valid,
    output logic [NUM_IN-1:0]        in_ready,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic [NUM_IN-1:0]        in_head,
    input  logic [NUM_IN-1:0]        in_tail,
    output logic [4:0]               out_valid,
    input  logic [4:0]               out_ready,
    output logic [5*DATA_W-1:0]      out_data,
    output logic [4:0]               out_head,
    output logic [4:0]               out_tail,
    output logic [7:0]               err_cnt
);
    localparam int NP = 5;
    localparam int IW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    localparam logic [2:0] P_LOCAL = 3'd0;
    localparam logic [2:0] P_EAST  = 3'd1;
    localparam logic [2:0] P_WEST  = 3'd2;
    localparam logic [2:0] P_NORTH = 3'd3;
    localparam logic [2:0] P_SOUTH = 3'd4;

    typedef enum logic {ST_IDLE, ST_LOCKED} port_st_e;

    port_st_e          st_q    [NP];
    port_st_e          st_d    [NP];
    logic [IW-1:0]     owner_q [NP];
    logic [IW-1:0]     owner_d [NP];
    logic [IW-1:0]     rr_q    [NP];
    logic [IW-1:0]     rr_d    [NP];
    logic [DATA_W-1:0] odata_q [NP];
    logic [DATA_W-1:0] odata_d [NP];
    logic [NP-1:0]     ovld_q, ovld_d;
    logic [NP-1:0]     ohead_q, ohead_d;
    logic [NP-1:0]     otail_q, otail_d;
    logic [NUM_IN-1:0] active_q, active_d;
    logic [2:0]        route_q [NUM_IN];
    logic [2:0]        route_d [NUM_IN];

    logic [NUM_IN-1:0][2:0] hdr_route;
    logic [NP-1:0]          out_free;
    logic [7:0]             free_pad;
    logic [NP-1:0]          gnt_vld;
    logic [IW-1:0]          gnt_idx [NP];
    logic [NUM_IN-1:0]      fire;
    int                     arb_j;
    logic [IW-1:0]          arb_idx;
    logic [IW-1:0]          src;
    logic                   load;

    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_route
        logic [COORD_W-1:0] dst_x;
        logic [COORD_W-1:0] dst_y;
        assign dst_x = in_data[gi*DATA_W +: COORD_W];
        assign dst_y = in_data[gi*DATA_W + COORD_W +: COORD_W];
        assign hdr_route[gi] = (dst_x != my_x) ? ((dst_x > my_x) ? P_EAST : P_WEST)
                             : (dst_y != my_y) ? ((dst_y > my_y) ? P_NORTH : P_SOUTH)
                             : P_LOCAL;
    end

    assign out_free = ~ovld_q | out_ready;
    assign free_pad = {3'b000, out_free};

    // Round-robin over idle-port requesters, search starting at rr_q.
    always_comb begin
        arb_j   = 0;
        arb_idx = '0;
        for (int p = 0; p < NP; p++) begin
            gnt_vld[p] = 1'b0;
            gnt_idx[p] = '0;
            if (st_q[p] == ST_IDLE) begin
                for (int k = 0; k < NUM_IN; k++) begin
                    arb_j = int'(rr_q[p]) + k;
                    if (arb_j >= NUM_IN) arb_j = arb_j - NUM_IN;
                    arb_idx = IW'(arb_j);
                    if (!gnt_vld[p] && in_valid[arb_idx] && in_head[arb_idx] &&
                        !active_q[arb_idx] && (hdr_route[arb_idx] == 3'(p))) begin
                        gnt_vld[p] = 1'b1;
                        gnt_idx[p] = arb_idx;
                    end
                end
            end
        end
    end

    // Locked inputs follow their port; idle non-head inputs are strays and are swallowed.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (active_q[i]) begin
                in_ready[i] = free_pad[route_q[i]];
            end else if (!in_head[i]) begin
                in_ready[i] = 1'b1;
            end
        end
        for (int p = 0; p < NP; p++) begin
            if (gnt_vld[p] && out_free[p]) in_ready[gnt_idx[p]] = 1'b1;
        end
        if (rst) in_ready = '0;
    end

    assign fire = in_valid & in_ready;

    always_comb begin
        active_d = active_q;
        src      = '0;
        load     = 1'b0;
        for (int i = 0; i < NUM_IN; i++) route_d[i] = route_q[i];
        for (int p = 0; p < NP; p++) begin
            st_d[p]    = st_q[p];
            owner_d[p] = owner_q[p];
            rr_d[p]    = rr_q[p];
            ovld_d[p]  = ovld_q[p] & ~out_ready[p];
            ohead_d[p] = ohead_q[p];
            otail_d[p] = otail_q[p];
            odata_d[p] = odata_q[p];
            if (st_q[p] == ST_IDLE) begin
                src  = gnt_idx[p];
                load = gnt_vld[p] & out_free[p];
            end else begin
                src  = owner_q[p];
                load = fire[owner_q[p]];
            end
            if (load) begin
                ovld_d[p]  = 1'b1;
                odata_d[p] = in_data[int'(src)*DATA_W +: DATA_W];
                ohead_d[p] = (st_q[p] == ST_IDLE);
                otail_d[p] = in_tail[src];
                case (st_q[p])
                    ST_IDLE: begin
                        rr_d[p] = (int'(src) == NUM_IN - 1) ? '0 : src + IW'(1);
                        if (!in_tail[src]) begin
                            st_d[p]       = ST_LOCKED;
                            owner_d[p]    = src;
                            active_d[src] = 1'b1;
                            route_d[src]  = 3'(p);
                        end
                    end
                    default: begin
                        if (in_tail[src]) begin
                            st_d[p]       = ST_IDLE;
                            active_d[src] = 1'b0;
                            route_d[src]  = '0;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= '0;
            ovld_q   <= '0;
            ohead_q  <= '0;
            otail_q  <= '0;
            for (int i = 0; i < NUM_IN; i++) route_q[i] <= '0;
            for (int p = 0; p < NP; p++) begin
                st_q[p]    <= ST_IDLE;
                owner_q[p] <= '0;
                rr_q[p]    <= '0;
                odata_q[p] <= '0;
            end
        end else begin
            active_q <= active_d;
            ovld_q   <= ovld_d;
            ohead_q  <= ohead_d;
            otail_q  <= otail_d;
            for (int i = 0; i < NUM_IN; i++) route_q[i] <= route_d[i];
            for (int p = 0; p < NP; p++) begin
                st_q[p]    <= st_d[p];
                owner_q[p] <= owner_d[p];
                rr_q[p]    <= rr_d[p];
                odata_q[p] <= odata_d[p];
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int p = 0; p < NP; p++) out_data[p*DATA_W +: DATA_W] = odata_q[p];
    end
    assign out_valid = ovld_q;
    assign out_head  = ohead_q;
    assign out_tail  = otail_q;

`ifdef XY_ROUTER_ERR_CNT_EN
    logic [NUM_IN-1:0] stray;
    logic [3:0]        n_stray;
    logic [8:0]        err_sum;
    logic [7:0]        err_cnt_q, err_cnt_d;

    assign stray = in_valid & ~active_q & ~in_head;

    // Several inputs can drop a stray in the same cycle; saturate at 255.
    always_comb begin
        n_stray = '0;
        for (int i = 0; i < NUM_IN; i++) n_stray = n_stray + 4'(stray[i]);
        err_sum   = {1'b0, err_cnt_q} + 9'(n_stray);
        err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_cnt_q <= '0;
        else     err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_xy_wormhole_router.sv
// Scoreboard bench for xy_wormhole_router at node (2,1): per-port expected-flit queues, negedge monitor.
module tb_xy_wormhole_router;
    localparam int NI = 4;
    localparam int CW = 4;
    localparam int DW = 32;
`ifdef XY_ROUTER_ERR_CNT_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic          head;
        logic          tail;
    } flit_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [CW-1:0]  my_x, my_y;
    logic [NI-1:0]  in_valid, in_ready, in_head, in_tail;
    logic [NI*DW-1:0] in_data;
    logic [4:0]     out_valid, out_ready, out_head, out_tail;
    logic [5*DW-1:0] out_data;
    logic [7:0]     err_cnt;

    int    checks = 0;
    int    errors = 0;
    flit_t drv_q [NI][$];
    flit_t exp_q [5][$];
    logic [NI-1:0] acc;

    always #5 clk = ~clk;

    xy_wormhole_router #(.NUM_IN(NI), .COORD_W(CW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .my_x(my_x), .my_y(my_y),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_head(in_head), .in_tail(in_tail),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_head(out_head), .out_tail(out_tail), .err_cnt(err_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mk(input int dx, input int dy, input int tag);
        logic [DW-1:0] d;
        d      = DW'(tag) << 8;
        d[3:0] = dx[3:0];
        d[7:4] = dy[3:0];
        return d;
    endfunction

    // fake_head marks body flits as heads too; the router must forward them as body flits.
    task automatic send(input int ch, input int dx, input int dy, input int n, input int tag,
                        input int port, input int n_exp, input bit fake_head);
        flit_t f;
        flit_t e;
        for (int k = 0; k < n; k++) begin
            f.data = (k == 0) ? mk(dx, dy, tag) : mk(k, 15 - k, tag + k);
            f.head = (k == 0) || fake_head;
            f.tail = (k == n - 1);
            drv_q[ch].push_back(f);
            e      = f;
            e.head = (k == 0);
            if (k < n_exp) exp_q[port].push_back(e);
        end
    endtask

    task automatic stray(input int ch, input int n);
        flit_t f;
        for (int k = 0; k < n; k++) begin
            f.data = mk(k % 16, 0, 'h500 + k);
            f.head = 1'b0;
            f.tail = (k % 2 == 1);
            drv_q[ch].push_back(f);
        end
    endtask

    function automatic bit idle();
        if (in_valid != '0 || out_valid != '0) return 1'b0;
        for (int c = 0; c < NI; c++) if (drv_q[c].size() != 0) return 1'b0;
        for (int p = 0; p < 5; p++) if (exp_q[p].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!idle() && n < 2000);
        chk(name, {63'd0, idle()}, 64'd1);
    endtask

    // Input driver: advance a channel only when its flit was accepted at the preceding edge.
    initial begin
        forever begin
            @(negedge clk);
            acc = in_valid & in_ready;
            @(posedge clk);
            #1;
            for (int c = 0; c < NI; c++) begin
                if (acc[c] && drv_q[c].size() > 0) void'(drv_q[c].pop_front());
                if (drv_q[c].size() > 0) begin
                    in_valid[c]          = 1'b1;
                    in_data[c*DW +: DW]  = drv_q[c][0].data;
                    in_head[c]           = drv_q[c][0].head;
                    in_tail[c]           = drv_q[c][0].tail;
                end else begin
                    in_valid[c] = 1'b0;
                    in_head[c]  = 1'b0;
                    in_tail[c]  = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor: a flit leaves a port whenever out_valid & out_ready.
    always @(negedge clk) begin
        if (!rst) begin
            for (int p = 0; p < 5; p++) begin
                if (out_valid[p] && out_ready[p]) begin
                    if (exp_q[p].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out port%0d: got data 0x%0h head %0b tail %0b, required no flit",
                                 p, out_data[p*DW +: DW], out_head[p], out_tail[p]);
                    end else begin
                        chk($sformatf("port%0d_flit", p),
                            64'({out_data[p*DW +: DW], out_head[p], out_tail[p]}),
                            64'(exp_q[p].pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish before 500000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        my_x      = 4'd2;
        my_y      = 4'd1;
        out_ready = '1;
        in_valid  = '1;
        in_head   = '0;
        in_tail   = '0;
        in_data   = '0;

        // Reset state, with stray-looking inputs present.
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_out_data", {63'd0, |out_data}, 0);
        chk("rst_out_marks", {out_head, out_tail}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_err_cnt", err_cnt, 0);

        // 3-flit packet to (5,1) -> east, one-cycle latency, body head marker stripped.
        send(0, 5, 1, 3, 'h100, 1, 3, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("t1_east_valid", out_valid[1], (k >= 2 && k <= 4) ? 64'd1 : 64'd0);
        end
        wait_drain("t1_drain");

        // Three simultaneous heads to (2,3) -> north, served 0,1,2 back to back.
        send(0, 2, 3, 3, 'h200, 3, 3, 1'b0);
        send(1, 2, 3, 3, 'h210, 3, 3, 1'b0);
        send(2, 2, 3, 3, 'h220, 3, 3, 1'b0);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            chk("t2_north_stream", out_valid[3], (k >= 2 && k <= 10) ? 64'd1 : 64'd0);
        end
        wait_drain("t2_drain_a");
        // Single-flit win by input 0 moves the pointer to 1, so 1 beats 0 next.
        send(0, 2, 3, 1, 'h230, 3, 1, 1'b0);
        wait_drain("t2_drain_b");
        send(1, 2, 3, 2, 'h240, 3, 2, 1'b0);
        send(0, 2, 3, 2, 'h250, 3, 2, 1'b0);
        wait_drain("t2_drain_c");

        // Head+tail to local then an immediate head to west from the same input.
        send(3, 2, 1, 1, 'h300, 0, 1, 1'b0);
        send(3, 0, 1, 1, 'h310, 2, 1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("t3_local_out", out_valid, 5'b00001);
        @(negedge clk);
        chk("t3_west_next", out_valid, 5'b00100);
        wait_drain("t3_drain");

        // South port stalled 4 cycles while a west packet keeps flowing.
        send(2, 2, 0, 4, 'h400, 4, 4, 1'b0);
        send(1, 0, 5, 4, 'h410, 2, 4, 1'b0);
        @(posedge clk); #2;
        @(posedge clk); #2;
        out_ready[4] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t4_owner_stalled", in_ready[2], 0);
            chk("t4_south_hold_vld", out_valid[4], 1);
            chk("t4_south_hold_dat", out_data[4*DW +: DW], mk(2, 0, 'h400));
            chk("t4_west_flowing", out_valid[2], 1);
        end
        @(posedge clk); #2;
        out_ready[4] = 1'b1;
        wait_drain("t4_drain");

        // Stray flits: dropped, counted only when the counter is built.
        chk("t5_err_start", err_cnt, 0);
        stray(1, 1);
        wait_drain("t5_drain_a");
        chk("t5_err_one", err_cnt, ERR_ON ? 64'd1 : 64'd0);
        stray(0, 60);
        stray(1, 60);
        stray(2, 60);
        wait_drain("t5_drain_b");
        chk("t5_err_181", err_cnt, ERR_ON ? 64'd181 : 64'd0);
        stray(0, 40);
        stray(1, 40);
        stray(3, 40);
        wait_drain("t5_drain_c");
        chk("t5_err_sat", err_cnt, ERR_ON ? 64'd255 : 64'd0);

        // Reset after two flits of a 4-flit packet; only the head ever leaves.
        send(0, 5, 1, 4, 'h600, 1, 1, 1'b0);
        @(posedge clk); #2;
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst = 1'b1;
        for (int c = 0; c < NI; c++) drv_q[c].delete();
        for (int p = 0; p < 5; p++) exp_q[p].delete();
        in_valid = '0;
        in_head  = '0;
        in_tail  = '0;
        @(negedge clk);
        chk("t6_rst_out_valid", out_valid, 0);
        chk("t6_rst_in_ready", in_ready, 0);
        chk("t6_rst_err_cnt", err_cnt, 0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_post_out_valid", out_valid, 0);
        send(0, 2, 5, 2, 'h620, 3, 2, 1'b0);
        send(3, 7, 1, 2, 'h630, 1, 2, 1'b0);
        wait_drain("t6_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
